// File: rtl/piso_ser_ctrl.sv
// piso_ser_ctrl: accepts parallel words over valid/ready, shifts each one out MSB
// first with frame_start/done markers, then holds off intake for GAP idle cycles.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_ser_ctrl #(
    parameter int N   = 8,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         frame_start,
    output logic         done,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

`ifdef PISO_PARITY_EN
    // The parity bit occupies one extra shift cycle at cnt == N.
    localparam logic [CW-1:0] LAST_CNT = CW'(N);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
`endif

    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic          HAS_GAP  = (GAP != 32'sd0);
    // The gap counter counts down to zero, so it is loaded with GAP-1.
    localparam logic [3:0]    GAP_LOAD = HAS_GAP ? 4'(GAP - 32'sd1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_r;
    state_t         nextState_s;
    logic [N-1:0]   shReg_r;
    logic [CW-1:0]  cnt_r;
    logic [3:0]     gCnt_r;
    logic           lastBit_s;
    logic           inReady_s;
    logic           accept_s;

`ifdef PISO_PARITY_EN
    logic           par_r;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic evenParity(input logic [N-1:0] word);
        return ^word;
    endfunction
`endif

    assign lastBit_s = (state_r == ST_SHIFT) && (cnt_r == LAST_CNT);
    assign accept_s  = in_valid & inReady_s;
    assign in_ready  = inReady_s;

    // Intake readiness depends only on state and count; forced low while in reset.
    always_comb begin
        inReady_s = 1'b0;
        if (rst) begin
            inReady_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  inReady_s = 1'b1;
                ST_SHIFT: inReady_s = lastBit_s & ~HAS_GAP;
                ST_GAP:   inReady_s = 1'b0;
                default:  inReady_s = 1'b0;
            endcase
        end
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decode: load on accept, leave SHIFT after the last frame bit.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    nextState_s = ST_SHIFT;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!lastBit_s) begin
                    nextState_s = ST_SHIFT;
                end else if (HAS_GAP) begin
                    nextState_s = ST_GAP;
                end else if (accept_s) begin
                    nextState_s = ST_SHIFT;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gCnt_r == 4'd0) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_GAP;
                end
            end
            default: nextState_s = ST_IDLE;
        endcase
    end

    // Datapath: word load on accept, left shift with zero fill, bit and gap counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shReg_r <= '0;
            cnt_r   <= CNT_ZERO;
            gCnt_r  <= 4'd0;
`ifdef PISO_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_SHIFT: begin
                    if (accept_s) begin
                        shReg_r <= in_data;
                        cnt_r   <= CNT_ZERO;
`ifdef PISO_PARITY_EN
                        par_r   <= evenParity(in_data);
`endif
                    end else if (state_r == ST_SHIFT) begin
                        shReg_r <= {shReg_r[N-2:0], 1'b0};
                        if (lastBit_s) begin
                            cnt_r  <= CNT_ZERO;
                            gCnt_r <= GAP_LOAD;
                        end else begin
                            cnt_r  <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gCnt_r != 4'd0) begin
                        gCnt_r <= gCnt_r - 4'd1;
                    end
                end
                default: begin
                    cnt_r  <= CNT_ZERO;
                    gCnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Output decode from registered state only; no input reaches these outputs.
    always_comb begin
        sout        = 1'b0;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_SHIFT: begin
                sout_valid  = 1'b1;
                busy        = 1'b1;
                frame_start = (cnt_r == CNT_ZERO);
                done        = lastBit_s;
`ifdef PISO_PARITY_EN
                if (cnt_r == LAST_CNT) begin
                    sout = par_r;
                end else begin
                    sout = shReg_r[N-1];
                end
`else
                sout = shReg_r[N-1];
`endif
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/piso_ser_ctrl.md
Name: piso_ser_ctrl

Overview:
- Sequencing controller for the team's parallel-in/serial-out shift path.
- Accepts parallel words from an upstream producer over a valid/ready handshake.
- Loads each word into an internal N-bit shift register and shifts it out MSB first, one bit per clock.
- Generates frame markers and inserts a programmable idle gap between frames; sits between a word source and a single-wire serial sink.

Parameters:
- N, 8, data word width in bits (N >= 2).
- GAP, 0, idle cycles inserted after each frame before the next word is accepted (0..15).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  N  parallel word to serialize
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  controller will accept in_data at this edge
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit this cycle
- frame_start  output  1  high on the first bit cycle of a frame
- done  output  1  high on the last bit cycle of a frame
- busy  output  1  high in SHIFT or GAP state

Behaviour:
- State is held in registers: state (IDLE/SHIFT/GAP), shreg[N-1:0], bit counter cnt (width clog2(N+1)), gap counter gcnt (4 bits).
- Reset (async, rst=1): state=IDLE, shreg=0, cnt=0, gcnt=0. All outputs are 0 while rst is high, including in_ready.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is issued and the partial word is discarded.
- IDLE:
  - in_ready=1, busy=0, sout_valid=0, sout=0.
  - Accept on edge where in_valid&in_ready: shreg<=in_data, cnt<=0, state<=SHIFT.
- SHIFT:
  - sout=shreg[N-1], sout_valid=1, busy=1.
  - frame_start=(cnt==0).
  - Each edge: shreg<=shreg<<1 (LSB fill 0), cnt<=cnt+1.
- Last data bit (cnt==N-1), parity disabled:
  - done=1.
  - If GAP==0: in_ready=1 in this cycle. An accept on this edge reloads shreg, clears cnt and stays in SHIFT, giving back-to-back frames with no dead cycle. Without an accept, state<=IDLE.
  - If GAP>0: in_ready=0; state<=GAP, gcnt<=GAP-1.
- GAP:
  - in_ready=0, sout_valid=0, sout=0, busy=1.
  - gcnt decrements each edge; at gcnt==0 state<=IDLE.
- Latency: a word accepted at edge k has its MSB on sout in the cycle after edge k and its LSB N-1 cycles later. Frame period = N + GAP cycles, plus one IDLE cycle per frame when GAP>0.
- in_ready is combinational from state and cnt only. It never depends on in_valid, so there is no combinational loop.
- in_data is sampled only at the accept edge. Changes at other times have no effect.
- in_valid held high with no accept possible (SHIFT/GAP): the word is held by the producer, not lost.
- Outputs other than in_ready are decoded from registered state: glitch-free relative to the clock, no input-to-output combinational paths.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - The controller latches par=^in_data (even parity) at accept.
  - After the N data bits, one extra SHIFT cycle (cnt==N) drives sout=par, sout_valid=1.
  - done moves to the parity cycle; the back-to-back in_ready window moves to the parity cycle.
  - Frame length = N+1.
- Not defined: frame is exactly N bits, no parity register is present, and the counter terminates at N-1.

Test Plan:
- Reset then idle, N=8, GAP=0: in_valid=0 → in_ready=1, sout_valid=0, busy=0 after rst release; all outputs 0 during rst.
- Single word 8'hA5, GAP=0:
  - sout over 8 cycles = 1,0,1,0,0,1,0,1.
  - frame_start on cycle 1 only, done on cycle 8, then IDLE.
- Back-to-back, GAP=0: in_valid held with 8'hFF then 8'h01 → 16 consecutive sout_valid cycles, sout=11111111 00000001, with frame_start on cycles 1 and 9.
- GAP=3, two words 8'hC3, 8'h3C:
  - in_ready=0 for 3 cycles after done, sout_valid=0 across the gap.
  - in_ready=1 in IDLE, second frame starts the cycle after its accept.
- Reset mid-frame: assert rst at bit 4 of 8'hF0 → sout_valid, busy and sout drop to 0 asynchronously, no done. The next word 8'h81 serializes correctly from its MSB.
- PISO_PARITY_EN, word 8'h07:
  - 9 bits = 00000111 then 1; done on cycle 9.
  - Word 8'h03 gives parity bit 0.
